// File: rtl/imm_encoder.sv
// ============================================================================
//  Module      : imm_encoder
//  Description : Scatters a signed 32-bit immediate into the I/S/B/J immediate
//                fields of an instruction word, with range/alignment flags.
//                Two-stage valid/ready pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       imm_type,
    input  logic [31:0]      imm,
    input  logic [31:0]      base_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err_range,
    output logic             err_align,
    output logic [CNT_W-1:0] enc_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0] c_type_i = 2'b00;
    localparam logic [1:0] c_type_s = 2'b01;
    localparam logic [1:0] c_type_b = 2'b10;
    localparam logic [1:0] c_type_j = 2'b11;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Stage 1 registers
    logic             r_s1_valid;
    logic [1:0]       r_s1_type;
    logic [31:0]      r_s1_imm;
    logic [31:0]      r_s1_base;

    // Stage 2 (output) registers
    logic             r_out_valid;
    logic [31:0]      r_instr;
    logic             r_err_range;
    logic             r_err_align;
    logic [CNT_W-1:0] r_enc_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_s1_advance;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [31:0]      w_instr;
    logic             w_is_ok;
    logic             w_b_ok;
    logic             w_j_ok;
    logic             w_err_range;
    logic             w_err_align;

    assign w_s1_advance = !r_out_valid || out_ready;
    assign in_ready     = !r_s1_valid || w_s1_advance;
    assign w_in_fire    = in_valid && in_ready;
    assign w_out_fire   = r_out_valid && out_ready;

    always_comb begin
        w_instr = r_s1_base;
        case (r_s1_type)
            c_type_i: begin
                w_instr[31:20] = r_s1_imm[11:0];
            end
            c_type_s: begin
                w_instr[31:25] = r_s1_imm[11:5];
                w_instr[11:7]  = r_s1_imm[4:0];
            end
            c_type_b: begin
                w_instr[31]    = r_s1_imm[12];
                w_instr[30:25] = r_s1_imm[10:5];
                w_instr[11:8]  = r_s1_imm[4:1];
                w_instr[7]     = r_s1_imm[11];
            end
            default: begin
                w_instr[31]    = r_s1_imm[20];
                w_instr[30:21] = r_s1_imm[10:1];
                w_instr[20]    = r_s1_imm[11];
                w_instr[19:12] = r_s1_imm[19:12];
            end
        endcase
    end

    // Representable iff every bit above the field's sign bit matches it
    assign w_is_ok = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
    assign w_b_ok  = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
    assign w_j_ok  = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

    always_comb begin
        w_err_range = 1'b0;
        case (r_s1_type)
            c_type_i, c_type_s: w_err_range = !w_is_ok;
            c_type_b:           w_err_range = !w_b_ok;
            c_type_j:           w_err_range = !w_j_ok;
            default:            w_err_range = 1'b0;
        endcase
    end

    assign w_err_align = r_s1_type[1] && r_s1_imm[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_type   <= 2'b00;
            r_s1_imm    <= 32'd0;
            r_s1_base   <= 32'd0;
            r_out_valid <= 1'b0;
            r_instr     <= 32'd0;
            r_err_range <= 1'b0;
            r_err_align <= 1'b0;
            r_enc_cnt   <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_in_fire) begin
                r_s1_type <= imm_type;
                r_s1_imm  <= imm;
                r_s1_base <= base_instr;
            end

            // Data registers only load with a real word so a drained stage keeps its last value
            if (w_s1_advance) begin
                r_out_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_instr     <= w_instr;
                    r_err_range <= w_err_range;
                    r_err_align <= w_err_align;
                end
            end

            if (w_out_fire) begin
                if (r_enc_cnt != '1) begin
                    r_enc_cnt <= r_enc_cnt + c_cnt_one;
                end
                if ((r_err_range || r_err_align) && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + c_cnt_one;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign instr     = r_instr;
    assign err_range = r_err_range;
    assign err_align = r_err_align;
    assign enc_cnt   = r_enc_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Scoreboard bench for imm_encoder (directed, backpressure,
//                reset flush, random round-trip).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_encoder;

    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    imm_type;
    logic [31:0]   imm;
    logic [31:0]   base_instr;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic          err_range;
    logic          err_align;
    logic [CW-1:0] enc_cnt;
    logic [CW-1:0] err_cnt;

    imm_encoder #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_type   (imm_type),
        .imm        (imm),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .err_range  (err_range),
        .err_align  (err_align),
        .enc_cnt    (enc_cnt),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        er;
        logic        ea;
        logic [1:0]  t;
        logic [31:0] imm;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_enc  = 0;
    int   exp_err  = 0;
    logic rand_done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_model(input logic [1:0] t, input logic [31:0] v,
                                              input logic [31:0] b);
        logic [31:0] w;
        w = b;
        if (t == 2'd0) begin
            w[31:20] = v[11:0];
        end else if (t == 2'd1) begin
            w[31:25] = v[11:5];
            w[11:7]  = v[4:0];
        end else if (t == 2'd2) begin
            w[31] = v[12]; w[30:25] = v[10:5]; w[11:8] = v[4:1]; w[7] = v[11];
        end else begin
            w[31] = v[20]; w[30:21] = v[10:1]; w[20] = v[11]; w[19:12] = v[19:12];
        end
        return w;
    endfunction

    function automatic logic range_model(input logic [1:0] t, input logic [31:0] v);
        int s;
        s = int'($signed(v));
        if (t <= 2'd1) return (s < -2048) || (s > 2047);
        if (t == 2'd2) return (s < -4096) || (s > 4095);
        return (s < -(1 << 20)) || (s > (1 << 20) - 1);
    endfunction

    function automatic logic [31:0] decode(input logic [31:0] i, input logic [1:0] t);
        case (t)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    task automatic send(input logic [1:0] t, input logic [31:0] v, input logic [31:0] b,
                        input logic [31:0] ei, input logic er, input logic ea);
        exp_t e;
        int   n;
        logic acc;
        imm_type   = t;
        imm        = v;
        base_instr = b;
        in_valid   = 1'b1;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            if (acc) begin
                e.instr = ei; e.er = er; e.ea = ea; e.t = t; e.imm = v;
                q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic send_model(input logic [1:0] t, input logic [31:0] v, input logic [31:0] b);
        send(t, v, b, enc_model(t, v, b), range_model(t, v), t[1] & v[0]);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    // Scoreboard monitor: a handshake seen at the negedge completes at the following posedge
    logic        prev_stall = 1'b0;
    logic [31:0] prev_instr;
    logic        prev_er;
    logic        prev_ea;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            exp_enc    = 0;
            exp_err    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_instr", {32'd0, instr}, {32'd0, prev_instr});
                chk("stall_flags", {62'd0, err_range, err_align}, {62'd0, prev_er, prev_ea});
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("instr", {32'd0, instr}, {32'd0, e.instr});
                    chk("err_range", {63'd0, err_range}, {63'd0, e.er});
                    chk("err_align", {63'd0, err_align}, {63'd0, e.ea});
                    if (!e.er && !e.ea) chk("roundtrip", {32'd0, decode(instr, e.t)}, {32'd0, e.imm});
                    if (exp_enc < CNT_MAX) exp_enc++;
                    if ((e.er || e.ea) && exp_err < CNT_MAX) exp_err++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_instr = instr;
            prev_er    = err_range;
            prev_ea    = err_align;
        end
    end

    logic [1:0]  rt;
    logic [31:0] rx;
    logic [31:0] rv;

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        imm_type   = 2'd0;
        imm        = 32'd0;
        base_instr = 32'd0;
        rand_done  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_instr", {32'd0, instr}, 64'd0);
        chk("rst_errs", {62'd0, err_range, err_align}, 64'd0);
        chk("rst_enc_cnt", {{(64-CW){1'b0}}, enc_cnt}, 64'd0);
        chk("rst_err_cnt", {{(64-CW){1'b0}}, err_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Directed encodings with hand-derived results
        out_ready = 1'b1;
        send(2'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 1'b0);
        send(2'd1, 32'h0000_07FF, 32'h0000_2023, 32'h7E00_2FA3, 1'b0, 1'b0);
        send(2'd1, 32'h0000_0800, 32'h0000_2023, 32'h8000_2023, 1'b1, 1'b0);
        send(2'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 1'b0);
        send(2'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b0, 1'b1);
        send(2'd3, 32'h000F_FFFE, 32'h0000_006F, 32'h7FFF_F06F, 1'b0, 1'b0);
        send(2'd3, 32'h0010_0000, 32'h0000_006F, 32'h8000_006F, 1'b1, 1'b0);
        drain();
        chk("dir_enc_cnt", {{(64-CW){1'b0}}, enc_cnt}, 64'd7);
        chk("dir_err_cnt", {{(64-CW){1'b0}}, err_cnt}, 64'd3);

        // Backpressure: toggling ready, then a hard stall
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send_model(2'd0, 32'(k * 17 - 20), $urandom);
            end
            begin
                repeat (12) begin
                    out_ready = ~out_ready;
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 4; k++) send_model(2'd1, 32'(100 - k * 9), $urandom);
            end
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
                chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_enc_cnt", {{(64-CW){1'b0}}, enc_cnt}, 64'd15);
        chk("bp_err_cnt", {{(64-CW){1'b0}}, err_cnt}, 64'd3);

        // Reset with two words in flight
        out_ready = 1'b0;
        send_model(2'd2, 32'h0000_0010, 32'h0000_0063);
        send_model(2'd3, 32'h0000_0100, 32'h0000_006F);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_enc_cnt", {{(64-CW){1'b0}}, enc_cnt}, 64'd0);
        chk("flush_err_cnt", {{(64-CW){1'b0}}, err_cnt}, 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("flush_no_out", {63'd0, out_valid}, 64'd0);
        chk("flush_enc_after", {{(64-CW){1'b0}}, enc_cnt}, 64'd0);

        // Random legal round-trip with random backpressure; counter saturates
        fork
            begin
                for (int k = 0; k < 10000; k++) begin
                    rt = 2'($urandom_range(0, 3));
                    rx = $urandom;
                    if (rt <= 2'd1)      rv = {{20{rx[11]}}, rx[11:0]};
                    else if (rt == 2'd2) rv = {{19{rx[12]}}, rx[12:1], 1'b0};
                    else                 rv = {{11{rx[20]}}, rx[20:1], 1'b0};
                    send_model(rt, rv, $urandom);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("sat_enc_cnt", {{(64-CW){1'b0}}, enc_cnt}, 64'(CNT_MAX));
        chk("rand_err_cnt", {{(64-CW){1'b0}}, err_cnt}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
